// File: rtl/butterfly_adder_pipe.sv
// Two-stage radix-2 butterfly adder: stage 1 forms widened sum/difference,
// stage 2 applies optional scaling and saturation/wrap with a sticky overflow flag.
module butterfly_adder_pipe #(
   parameter int unsigned bit_width = 16,
   parameter int unsigned SIZE      = 4,
   parameter int unsigned SCALE     = 0,
   parameter int unsigned SAT       = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [3:0]                  stage_FFT,
   input  logic signed [bit_width-1:0] xin1,
   input  logic signed [bit_width-1:0] yin1,
   input  logic signed [bit_width-1:0] xin2,
   input  logic signed [bit_width-1:0] yin2,
   input  logic signed [bit_width-1:0] xin3,
   input  logic signed [bit_width-1:0] yin3,
   input  logic                        en,
   input  logic                        delay,
   input  logic                        clr_ovf,
   output logic signed [bit_width-1:0] xout1,
   output logic signed [bit_width-1:0] yout1,
   output logic signed [bit_width-1:0] xout2,
   output logic signed [bit_width-1:0] yout2,
   output logic                        out_valid,
   output logic                        ovf
);

   localparam int unsigned W1 = bit_width + 1;

   logic [W1-1:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
   logic          v1_q, v1_d;
   logic [bit_width-1:0] xout1_q, xout1_d, xout2_q, xout2_d;
   logic [bit_width-1:0] yout1_q, yout1_d, yout2_q, yout2_d;
   logic          out_valid_q, out_valid_d;
   logic          ovf_q, ovf_d;

   // Floor divide by two on the widened value when scaling is enabled.
   function automatic logic [W1-1:0] scale_f(input logic [W1-1:0] v);
      return (SCALE != 0) ? {v[W1-1], v[W1-1:1]} : v;
   endfunction

   // A widened value fits in bit_width bits iff its top two bits agree.
   function automatic logic oor_f(input logic [W1-1:0] v);
      return v[W1-1] ^ v[W1-2];
   endfunction

   function automatic logic [bit_width-1:0] fit_f(input logic [W1-1:0] v);
      if ((SAT != 0) && oor_f(v))
         return v[W1-1] ? {1'b1, {(bit_width-1){1'b0}}} : {1'b0, {(bit_width-1){1'b1}}};
      return v[bit_width-1:0];
   endfunction

   logic          valid_in, last_stage;
   logic [W1-1:0] xa, xb, xc, ya, yb, yc;
   logic [W1-1:0] sx1, sx2, sy1, sy2;
   logic          oor_any;

   // Stage 1: sample operands and mode together on a valid beat.
   always_comb begin
      valid_in   = en | delay;
      last_stage = 32'(stage_FFT) >= SIZE;
      xa = {xin1[bit_width-1], xin1};
      xb = {xin2[bit_width-1], xin2};
      xc = {xin3[bit_width-1], xin3};
      ya = {yin1[bit_width-1], yin1};
      yb = {yin2[bit_width-1], yin2};
      yc = {yin3[bit_width-1], yin3};
      x1_d = x1_q;
      x2_d = x2_q;
      y1_d = y1_q;
      y2_d = y2_q;
      v1_d = valid_in;
      if (valid_in) begin
         x1_d = xa + xb;
         y1_d = ya + yb;
         x2_d = last_stage ? (xa + xc) : (xa - xb);
         y2_d = last_stage ? (ya + yc) : (ya - yb);
      end
   end

   // Stage 2: scale, range-check and clamp/wrap; outputs hold between beats.
   always_comb begin
      sx1 = scale_f(x1_q);
      sx2 = scale_f(x2_q);
      sy1 = scale_f(y1_q);
      sy2 = scale_f(y2_q);
      oor_any = oor_f(sx1) | oor_f(sx2) | oor_f(sy1) | oor_f(sy2);
      xout1_d = xout1_q;
      xout2_d = xout2_q;
      yout1_d = yout1_q;
      yout2_d = yout2_q;
      out_valid_d = v1_q;
      if (v1_q) begin
         xout1_d = fit_f(sx1);
         xout2_d = fit_f(sx2);
         yout1_d = fit_f(sy1);
         yout2_d = fit_f(sy2);
      end
      // Set has priority over clear.
      ovf_d = (ovf_q & ~clr_ovf) | (v1_q & oor_any);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x1_q        <= '0;
         x2_q        <= '0;
         y1_q        <= '0;
         y2_q        <= '0;
         v1_q        <= 1'b0;
         xout1_q     <= '0;
         xout2_q     <= '0;
         yout1_q     <= '0;
         yout2_q     <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         y1_q        <= y1_d;
         y2_q        <= y2_d;
         v1_q        <= v1_d;
         xout1_q     <= xout1_d;
         xout2_q     <= xout2_d;
         yout1_q     <= yout1_d;
         yout2_q     <= yout2_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign xout1     = xout1_q;
   assign xout2     = xout2_q;
   assign yout1     = yout1_q;
   assign yout2     = yout2_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_adder_pipe.sv
// Directed bench for butterfly_adder_pipe: default, scaled and wrapping instances share stimulus.
module tb_butterfly_adder_pipe;

   localparam int unsigned BW = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] stage_FFT;
   logic signed [BW-1:0] xin1, yin1, xin2, yin2, xin3, yin3;
   logic en, delay, clr_ovf;

   logic signed [BW-1:0] d_x1, d_y1, d_x2, d_y2;
   logic                 d_v, d_ovf;
   logic signed [BW-1:0] s_x1, s_y1, s_x2, s_y2;
   logic                 s_v, s_ovf;
   logic signed [BW-1:0] w_x1, w_y1, w_x2, w_y2;
   logic                 w_v, w_ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   butterfly_adder_pipe #(.bit_width(BW), .SIZE(4), .SCALE(0), .SAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .stage_FFT(stage_FFT),
      .xin1(xin1), .yin1(yin1), .xin2(xin2), .yin2(yin2), .xin3(xin3), .yin3(yin3),
      .en(en), .delay(delay), .clr_ovf(clr_ovf),
      .xout1(d_x1), .yout1(d_y1), .xout2(d_x2), .yout2(d_y2),
      .out_valid(d_v), .ovf(d_ovf));

   butterfly_adder_pipe #(.bit_width(BW), .SIZE(4), .SCALE(1), .SAT(1)) u_dut_scale (
      .clk(clk), .rst_n(rst_n), .stage_FFT(stage_FFT),
      .xin1(xin1), .yin1(yin1), .xin2(xin2), .yin2(yin2), .xin3(xin3), .yin3(yin3),
      .en(en), .delay(delay), .clr_ovf(clr_ovf),
      .xout1(s_x1), .yout1(s_y1), .xout2(s_x2), .yout2(s_y2),
      .out_valid(s_v), .ovf(s_ovf));

   butterfly_adder_pipe #(.bit_width(BW), .SIZE(4), .SCALE(0), .SAT(0)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n), .stage_FFT(stage_FFT),
      .xin1(xin1), .yin1(yin1), .xin2(xin2), .yin2(yin2), .xin3(xin3), .yin3(yin3),
      .en(en), .delay(delay), .clr_ovf(clr_ovf),
      .xout1(w_x1), .yout1(w_y1), .xout2(w_x2), .yout2(w_y2),
      .out_valid(w_v), .ovf(w_ovf));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] st, input logic e, input logic d,
                        input int a1, input int a2, input int a3,
                        input int b1, input int b2, input int b3);
      stage_FFT = st;
      en        = e;
      delay     = d;
      xin1 = BW'(a1); xin2 = BW'(a2); xin3 = BW'(a3);
      yin1 = BW'(b1); yin2 = BW'(b2); yin3 = BW'(b3);
   endtask

   task automatic idle();
      en    = 1'b0;
      delay = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      clr_ovf = 1'b0;
      drive(4'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("reset_xout1", 32'(d_x1), 0);
      chk("reset_valid", 32'(d_v), 0);
      chk("reset_ovf", 32'(d_ovf), 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Basic butterfly, stage below SIZE: sum and difference.
      drive(4'd1, 1'b1, 1'b0, 100, 20, 0, -7, 3, 0);
      step(); idle();
      chk("b1_early_valid", 32'(d_v), 0);
      step();
      chk("b1_valid", 32'(d_v), 1);
      chk("b1_xout1", 32'(d_x1), 120);
      chk("b1_xout2", 32'(d_x2), 80);
      chk("b1_yout1", 32'(d_y1), -4);
      chk("b1_yout2", 32'(d_y2), -10);
      step();
      chk("b1_valid_pulse", 32'(d_v), 0);

      // Last stage via delay: out2 = in1 + in3.
      drive(4'd4, 1'b0, 1'b1, 100, 20, -5, 0, 0, 0);
      step(); idle(); step();
      chk("last_valid", 32'(d_v), 1);
      chk("last_xout1", 32'(d_x1), 120);
      chk("last_xout2", 32'(d_x2), 95);
      step();

      // Positive overflow: saturate, scale, wrap.
      drive(4'd1, 1'b1, 1'b0, 30000, 10000, 0, 0, 0, 0);
      step(); idle(); step();
      chk("sat_xout1", 32'(d_x1), 32767);
      chk("sat_xout2", 32'(d_x2), 20000);
      chk("sat_ovf", 32'(d_ovf), 1);
      chk("scale_xout1", 32'(s_x1), 20000);
      chk("scale_xout2", 32'(s_x2), 10000);
      chk("scale_ovf", 32'(s_ovf), 0);
      chk("wrap_xout1", 32'(w_x1), -25536);
      chk("wrap_ovf", 32'(w_ovf), 1);
      step(); step();
      chk("sat_ovf_sticky", 32'(d_ovf), 1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("sat_ovf_cleared", 32'(d_ovf), 0);

      // Overflow beat arriving while clear is held: set wins.
      drive(4'd1, 1'b1, 1'b0, 30000, 10000, 0, 0, 0, 0);
      clr_ovf = 1'b1;
      step(); idle(); step();
      chk("set_wins_ovf", 32'(d_ovf), 1);
      clr_ovf = 1'b0;
      step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;

      // Floor rounding of negative odd value under scaling.
      drive(4'd1, 1'b1, 1'b0, -3, 0, 0, 0, 0, 0);
      step(); idle(); step();
      chk("floor_scale_x1", 32'(s_x1), -2);
      chk("floor_scale_x2", 32'(s_x2), -2);
      chk("floor_plain_x1", 32'(d_x1), -3);
      step();

      // Three back-to-back beats, then hold.
      drive(4'd1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0);
      step();
      drive(4'd1, 1'b1, 1'b0, 2, 0, 0, 0, 0, 0);
      step();
      drive(4'd1, 1'b1, 1'b0, 3, 0, 0, 0, 0, 0);
      chk("b2b_v1", 32'(d_v), 1);
      chk("b2b_x1", 32'(d_x1), 1);
      step(); idle();
      chk("b2b_v2", 32'(d_v), 1);
      chk("b2b_x2", 32'(d_x1), 2);
      step();
      chk("b2b_v3", 32'(d_v), 1);
      chk("b2b_x3", 32'(d_x1), 3);
      step();
      chk("hold_valid", 32'(d_v), 0);
      chk("hold_xout1", 32'(d_x1), 3);
      step();
      chk("hold_xout1_2", 32'(d_x1), 3);

      // Reset while a beat is in flight.
      drive(4'd1, 1'b1, 1'b0, 50, 0, 0, 0, 0, 0);
      step(); idle();
      rst_n = 1'b0;
      #1;
      chk("rst_xout1", 32'(d_x1), 0);
      chk("rst_valid", 32'(d_v), 0);
      chk("rst_wrap_ovf", 32'(w_ovf), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_no_valid_a", 32'(d_v), 0);
      step();
      chk("rst_no_valid_b", 32'(d_v), 0);
      chk("rst_xout1_hold", 32'(d_x1), 0);

      // First beat after reset.
      drive(4'd1, 1'b1, 1'b0, 7, 1, 0, 0, 0, 0);
      step(); idle();
      chk("post_early_valid", 32'(d_v), 0);
      step();
      chk("post_valid", 32'(d_v), 1);
      chk("post_xout1", 32'(d_x1), 8);
      chk("post_xout2", 32'(d_x2), 6);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
